rr_bus_arbiter_4req: RTL and testbench

- Round-robin arbiter/scheduler for a shared 32-bit write path.
- Four requesters (A–D) each present a 32-bit word and a request bit. The block grants one requester at a time and drives the 2-bit select of the shared 4:1 32-bit word mux.
- It presents the selected word with a valid/ack handshake to the downstream consumer (register-file write port or memory store port).
- It bounds how long one requester holds the path while others wait.

---
 rtl/rr_bus_arbiter_4req_if.sv | 26 ++
 rtl/rr_bus_arbiter_4req.sv | 118 +++++++++++
 tb/tb_rr_bus_arbiter_4req.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_4req_if.sv
// Requester/consumer bundle for the 4-way round-robin write-path arbiter.
// master is the arbiter side; slave is the requester/consumer side.
interface rr_bus_arbiter_4req_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            req;
    logic [DATA_WIDTH-1:0] inA;
    logic [DATA_WIDTH-1:0] inB;
    logic [DATA_WIDTH-1:0] inC;
    logic [DATA_WIDTH-1:0] inD;
    logic                  ack;
    logic [3:0]            gnt;
    logic [1:0]            sel;
    logic [DATA_WIDTH-1:0] out;
    logic                  valid;

    modport master (
        input  req, inA, inB, inC, inD, ack,
        output gnt, sel, out, valid
    );

    modport slave (
        output req, inA, inB, inC, inD, ack,
        input  gnt, sel, out, valid
    );
endinterface

// File: rtl/rr_bus_arbiter_4req.sv
// Round-robin arbiter for a shared write path: four requesters, one
// registered grant, valid/ack handshake and a per-grant hold limit.
module rr_bus_arbiter_4req #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input logic                 Clk,
    input logic                 Rst,
    rr_bus_arbiter_4req_if.master bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] GRANT    = 1'b1;
    localparam logic [4:0] HOLD_LIM = 5'(MAX_HOLD);

    logic [0:0] state;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] last;
    logic [3:0] hold_cnt;

    logic            owner_req;
    logic            valid;
    logic            xfer;
    logic [3:0]      own_oh;
    logic            others_req;
    logic [4:0]      hold_nx;
    logic            hold_hit;
    logic            force_rel;
    logic [1:0]      idle_pick;
    logic [1:0]      rel_pick;
    logic [DATA_WIDTH-1:0] out_mux;

    // First set request strictly after base, wrapping; base itself is last.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] r,
        input logic [1:0] base
    );
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign owner_req  = bus.req[sel];
    assign valid      = (state == GRANT) && owner_req;
    assign xfer       = valid && bus.ack;
    assign own_oh     = 4'b0001 << sel;
    assign others_req = |(bus.req & ~own_oh);
    assign hold_nx    = {1'b0, hold_cnt} + 5'd1;
    // >= so a saturated counter still yields to a late contender
    assign hold_hit   = hold_nx >= HOLD_LIM;
    assign force_rel  = xfer && hold_hit && others_req;
    assign idle_pick  = rr_pick(bus.req, last);
    assign rel_pick   = rr_pick(bus.req, sel);

    always_comb begin
        out_mux = bus.inA;
        case (sel)
            2'd0:    out_mux = bus.inA;
            2'd1:    out_mux = bus.inB;
            2'd2:    out_mux = bus.inC;
            default: out_mux = bus.inD;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state    <= GRANT;
                        gnt      <= 4'b0001 << idle_pick;
                        sel      <= idle_pick;
                        hold_cnt <= 4'd0;
                    end
                end
                default: begin
                    if (!owner_req) begin
                        last     <= sel;
                        hold_cnt <= 4'd0;
                        if (|bus.req) begin
                            gnt <= 4'b0001 << rel_pick;
                            sel <= rel_pick;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end
                    end else if (force_rel) begin
                        last     <= sel;
                        gnt      <= 4'b0001 << rel_pick;
                        sel      <= rel_pick;
                        hold_cnt <= 4'd0;
                    end else if (xfer && hold_cnt != 4'd15) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.sel   = sel;
    assign bus.out   = out_mux;
    assign bus.valid = valid;
endmodule

// File: tb/tb_rr_bus_arbiter_4req.sv
// Directed bench: u4 runs MAX_HOLD=4, u1 runs MAX_HOLD=1, same stimulus.
module tb_rr_bus_arbiter_4req;
    logic Clk = 1'b0;
    logic Rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    rr_bus_arbiter_4req_if #(.DATA_WIDTH(32)) b4 ();
    rr_bus_arbiter_4req_if #(.DATA_WIDTH(32)) b1 ();

    assign b1.req = b4.req;
    assign b1.inA = b4.inA;
    assign b1.inB = b4.inB;
    assign b1.inC = b4.inC;
    assign b1.inD = b4.inD;
    assign b1.ack = b4.ack;

    rr_bus_arbiter_4req #(.DATA_WIDTH(32), .MAX_HOLD(4)) u4 (
        .Clk(Clk), .Rst(Rst), .bus(b4)
    );
    rr_bus_arbiter_4req #(.DATA_WIDTH(32), .MAX_HOLD(1)) u1 (
        .Clk(Clk), .Rst(Rst), .bus(b1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst    = 1'b1;
        b4.req = 4'b0000;
        b4.ack = 1'b0;
        step();
        step();
        Rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  rr_gnt [5];
        logic [31:0] rr_dat [5];
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        b4.inA = 32'hDEADBEEF;
        b4.inB = 32'h1111_2222;
        b4.inC = 32'h3333_4444;
        b4.inD = 32'h5555_6666;
        rr_dat = '{32'hDEADBEEF, 32'h1111_2222, 32'h3333_4444,
                   32'h5555_6666, 32'hDEADBEEF};
        Rst    = 1'b1;
        b4.req = 4'b0000;
        b4.ack = 1'b0;
        #2;
        chk("rst_gnt", 32'(b4.gnt), 32'h0);
        chk("rst_sel", 32'(b4.sel), 32'h0);
        chk("rst_valid", 32'(b4.valid), 32'h0);
        chk("rst_out", b4.out, 32'hDEADBEEF);
        do_reset();
        step();
        chk("idle_gnt", 32'(b4.gnt), 32'h0);

        // single requester, held with no contender
        b4.req = 4'b0001;
        b4.ack = 1'b1;
        #1;
        chk("lat_gnt0", 32'(b4.gnt), 32'h0);
        step();
        chk("single_gnt", 32'(b4.gnt), 32'h1);
        chk("single_sel", 32'(b4.sel), 32'h0);
        chk("single_valid", 32'(b4.valid), 32'h1);
        chk("single_out", b4.out, 32'hDEADBEEF);
        repeat (20) step();
        chk("sat_gnt4", 32'(b4.gnt), 32'h1);
        chk("sat_gnt1", 32'(b1.gnt), 32'h1);

        // late contender after saturation: release after next transfer
        b4.req = 4'b0101;
        step();
        chk("fair_gnt", 32'(b4.gnt), 32'h4);
        chk("fair_out", b4.out, 32'h3333_4444);

        // voluntary drop by C with A pending
        b4.req = 4'b0001;
        #1;
        chk("drop_valid", 32'(b4.valid), 32'h0);
        step();
        chk("drop_gnt", 32'(b4.gnt), 32'h1);
        chk("drop_valid2", 32'(b4.valid), 32'h1);
        b4.req = 4'b0000;
        step();
        chk("drop_idle", 32'(b4.gnt), 32'h0);
        chk("drop_idle_v", 32'(b4.valid), 32'h0);

        // round robin on MAX_HOLD=1
        do_reset();
        b4.req = 4'b1111;
        b4.ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr_gnt%0d", i), 32'(b1.gnt), 32'(rr_gnt[i]));
            chk($sformatf("rr_sel%0d", i), 32'(b1.sel), 32'(i % 4));
            chk($sformatf("rr_out%0d", i), b1.out, rr_dat[i]);
        end

        // hold limit on MAX_HOLD=4
        do_reset();
        b4.req = 4'b0001;
        b4.ack = 1'b1;
        step();
        chk("hold_first", 32'(b4.gnt), 32'h1);
        b4.req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_keep%0d", i), 32'(b4.gnt), 32'h1);
        end
        step();
        chk("hold_rel_gnt", 32'(b4.gnt), 32'h4);
        chk("hold_rel_out", b4.out, 32'h3333_4444);

        // backpressure: B owns, ack low, C waiting
        do_reset();
        b4.req = 4'b0010;
        step();
        b4.req = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_gnt%0d", i), 32'(b4.gnt), 32'h2);
            chk($sformatf("bp_sel%0d", i), 32'(b4.sel), 32'h1);
        end
        chk("bp_valid", 32'(b4.valid), 32'h1);
        b4.ack = 1'b1;
        repeat (3) step();
        chk("bp_cnt_kept", 32'(b4.gnt), 32'h2);
        step();
        chk("bp_rel", 32'(b4.gnt), 32'h4);

        // async reset during a D grant
        do_reset();
        b4.req = 4'b1000;
        step();
        chk("d_gnt", 32'(b4.gnt), 32'h8);
        chk("d_sel", 32'(b4.sel), 32'h3);
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(b4.gnt), 32'h0);
        chk("arst_sel", 32'(b4.sel), 32'h0);
        chk("arst_valid", 32'(b4.valid), 32'h0);
        step();
        Rst    = 1'b0;
        b4.req = 4'b1111;
        step();
        chk("arst_first", 32'(b4.gnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
